apb_slave_mem: RTL and testbench

- Word-addressed APB memory responder that sits directly downstream of the APB interconnect DUT.
- Consumes the slave-side request bus (psel_s, penable_s, pwrite_s, paddr_s, pwdata_s, pstrb_s, pprot_s) and produces the response (prdata_s0, pready_s0, pslverr_s0) that the interconnect returns to the master.
- Provides a synthesizable RTL target with programmable wait states and error responses.
- Allows the system bench to run without an active slave VIP.

---
 rtl/apb_slave_mem.sv | 169 ++++++++++++++++
 tb/tb_apb_slave_mem.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_mem.sv
// Word-addressed APB memory responder with a fixed number of wait states and
// error responses for out-of-range or misaligned accesses. All outputs are registered.
module apb_slave_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int SEL_WIDTH   = 1,
  parameter int SEL_IDX     = 0,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic [SEL_WIDTH-1:0]    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [2:0]              pprot,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_WIDTH - LSB;
  localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                  state, state_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic                    sel;
  logic [IDX_W-1:0]        idx;
  logic                    oor, misal, err_c;
  logic                    setup_acc, complete, use_live;

  logic                    wr_q, err_q;
  logic [MEM_AW-1:0]       idx_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_W-1:0]       strb_q;

  logic                    c_wr, c_err;
  logic [MEM_AW-1:0]       c_idx;
  logic [DATA_WIDTH-1:0]   c_wdata;
  logic [STRB_W-1:0]       c_strb;

  logic                    pready_n, pslverr_n;
  logic [DATA_WIDTH-1:0]   prdata_n;

  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

  logic                    unused_ok;

  assign unused_ok = ^pprot;

  assign sel = psel[SEL_IDX];
  assign idx = paddr[ADDR_WIDTH-1:LSB];
  assign oor = {{(64-IDX_W){1'b0}}, idx} >= 64'(MEM_DEPTH);

  generate
    if (LSB > 0) begin : g_align
      assign misal = |paddr[LSB-1:0];
    end else begin : g_noalign
      assign misal = 1'b0;
    end
  endgenerate

  assign err_c = oor | misal;

  // Request capture: only the setup-phase values are used for the transfer.
  always_ff @(posedge pclk) begin
    if (setup_acc) begin
      wr_q    <= pwrite;
      err_q   <= err_c;
      idx_q   <= idx[MEM_AW-1:0];
      wdata_q <= pwdata;
      strb_q  <= pstrb;
    end
  end

  // With zero wait states the transfer completes on the setup edge, so pready is
  // already high during the first access cycle; that path uses the live request.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    setup_acc = 1'b0;
    complete  = 1'b0;
    use_live  = 1'b0;
    case (state)
      IDLE: begin
        if (sel && !penable) begin
          setup_acc = 1'b1;
          if (WAIT_STATES == 0) begin
            complete = 1'b1;
            use_live = 1'b1;
            state_n  = DONE;
          end else begin
            cnt_n   = CNT_W'(WAIT_STATES - 1);
            state_n = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (!sel) begin
          state_n = IDLE;
        end else if (penable) begin
          if (cnt != '0) begin
            cnt_n = cnt - 1'b1;
          end else begin
            complete = 1'b1;
            state_n  = DONE;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_comb begin
    c_wr    = use_live ? pwrite           : wr_q;
    c_err   = use_live ? err_c            : err_q;
    c_idx   = use_live ? idx[MEM_AW-1:0]  : idx_q;
    c_wdata = use_live ? pwdata           : wdata_q;
    c_strb  = use_live ? pstrb            : strb_q;

    pready_n  = complete;
    pslverr_n = complete & c_err;
    prdata_n  = '0;
    if (complete && !c_wr && !c_err) begin
      prdata_n = mem[c_idx];
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state   <= IDLE;
      cnt     <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      pready  <= pready_n;
      pslverr <= pslverr_n;
      prdata  <= prdata_n;
    end
  end

  // Byte-lane write on the completion edge; an edge seen while in reset is dropped.
  always_ff @(posedge pclk) begin
    if (complete && c_wr && !c_err && !preset) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (c_strb[b]) begin
          mem[c_idx][b*8 +: 8] <= c_wdata[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed and randomized checks of apb_slave_mem at two wait-state settings,
// against a word-array reference model of the memory.
module tb_apb_slave_mem;

  logic        pclk = 1'b0;
  logic        preset;
  logic        sel;
  int          cur;
  logic [0:0]  psel2, psel0;
  logic        penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] prdata2, prdata0;
  logic        pready2, pready0, pslverr2, pslverr0;
  logic        rdy, slverr;
  logic [31:0] rdata;

  int ncmp  = 0;
  int nfail = 0;

  logic [31:0] model [2][256];
  bit          known [2][256];

  always #5 pclk = ~pclk;

  assign psel2  = (sel && cur == 2) ? 1'b1 : 1'b0;
  assign psel0  = (sel && cur == 0) ? 1'b1 : 1'b0;
  assign rdy    = (cur == 0) ? pready0  : pready2;
  assign slverr = (cur == 0) ? pslverr0 : pslverr2;
  assign rdata  = (cur == 0) ? prdata0  : prdata2;

  apb_slave_mem #(.WAIT_STATES(2)) dut2 (
    .pclk(pclk), .preset(preset), .psel(psel2), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .prdata(prdata2), .pready(pready2), .pslverr(pslverr2)
  );

  apb_slave_mem #(.WAIT_STATES(0)) dut0 (
    .pclk(pclk), .preset(preset), .psel(psel0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic bit exp_err(input logic [31:0] a);
    return ((a >> 2) >= 32'd256) || (a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // One APB transfer driven on falling edges; returns at the falling edge where pready is high.
  task automatic xfer(input int w, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int abort_at, output logic [31:0] rd,
                      output logic er, output int waits, output bit done);
    @(negedge pclk);
    cur = w; sel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    pprot = 3'($urandom);
    @(negedge pclk);
    penable = 1'b1;
    paddr = $urandom; pwdata = $urandom; pwrite = ~wr;
    waits = 0; done = 1'b0; rd = '0; er = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (abort_at >= 0 && i == abort_at) begin
        sel = 1'b0; penable = 1'b0;
        break;
      end
      if (rdy === 1'b1) begin
        done = 1'b1; rd = rdata; er = slverr;
        break;
      end
      waits++;
      @(negedge pclk);
    end
  endtask

  task automatic txn(input int w, input bit wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd);
    logic er;
    int   waits;
    bit   done;
    int   k;
    bit   e;
    k = (w == 0) ? 0 : 1;
    e = exp_err(a);
    xfer(w, wr, a, d, s, -1, rd, er, waits, done);
    chk("done", done, 1);
    if (done) begin
      chk("waits", waits, w);
      chk("slverr", er, e);
      if (!wr) begin
        if (e) chk("rdata_err", rd, 0);
        else if (known[k][a >> 2]) chk("rdata", rd, model[k][a >> 2]);
      end else if (!e) begin
        model[k][a >> 2] = merge(known[k][a >> 2] ? model[k][a >> 2] : 32'h0, d, s);
        if (!known[k][a >> 2] && s != 4'hF) model[k][a >> 2] = 'x;
        else known[k][a >> 2] = 1'b1;
      end
    end
  endtask

  task automatic idle();
    @(negedge pclk);
    sel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    logic [31:0] rd, a, d;
    logic        er;
    int          waits;
    bit          done;
    int          w, r;

    preset = 1'b1; sel = 1'b0; cur = 2; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
    for (int k = 0; k < 2; k++) for (int i = 0; i < 256; i++) known[k][i] = 1'b0;
    repeat (2) @(negedge pclk);
    chk("rst_pready2", pready2, 0);
    chk("rst_pslverr2", pslverr2, 0);
    chk("rst_prdata2", prdata2, 0);
    chk("rst_pready0", pready0, 0);
    preset = 1'b0;

    for (int i = 0; i < 64; i++) begin
      txn(2, 1'b1, 32'(i * 4), $urandom, 4'hF, rd);
      txn(0, 1'b1, 32'(i * 4), $urandom, 4'hF, rd);
    end
    idle();

    txn(2, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd);
    txn(2, 1'b0, 32'h10, 32'h0, 4'h0, rd);
    chk("deadbeef", rd, 32'hDEADBEEF);
    idle();
    chk("pready_one_cycle", pready2, 0);
    chk("prdata_cleared", prdata2, 0);

    txn(2, 1'b1, 32'h20, 32'h11223344, 4'hF, rd);
    txn(2, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, rd);
    txn(2, 1'b0, 32'h20, 32'h0, 4'h0, rd);
    chk("strobe_merge", rd, 32'h11BB33DD);

    txn(2, 1'b0, 32'h400, 32'h0, 4'h0, rd);
    txn(2, 1'b1, 32'h400, 32'h12345678, 4'hF, rd);
    txn(2, 1'b1, 32'h13, 32'h12345678, 4'hF, rd);
    txn(2, 1'b0, 32'h10, 32'h0, 4'h0, rd);
    chk("err_no_side_effect", rd, 32'hDEADBEEF);
    idle();

    txn(0, 1'b1, 32'h04, 32'hA5A55A5A, 4'hF, rd);
    txn(0, 1'b0, 32'h04, 32'h0, 4'h0, rd);
    chk("ws0_b2b_read", rd, 32'hA5A55A5A);
    idle();

    xfer(2, 1'b1, 32'h08, 32'h0BADF00D, 4'hF, 1, rd, er, waits, done);
    chk("abort_not_done", done, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge pclk);
      chk("abort_pready_low", pready2, 0);
    end
    txn(2, 1'b0, 32'h08, 32'h0, 4'h0, rd);
    chk("abort_kept_value", rd, model[1][2]);
    idle();

    @(negedge pclk);
    cur = 2; sel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C;
    pwdata = ~model[1][3]; pstrb = 4'hF;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    preset = 1'b1;
    #1;
    chk("midrst_pready", pready2, 0);
    chk("midrst_pslverr", pslverr2, 0);
    @(negedge pclk);
    @(negedge pclk);
    preset = 1'b0; sel = 1'b0; penable = 1'b0;
    txn(2, 1'b0, 32'h0C, 32'h0, 4'h0, rd);

    txn(2, 1'b0, 32'h10, 32'h0, 4'h0, rd);
    #1 preset = 1'b1;
    #1;
    chk("async_pready", pready2, 0);
    chk("async_prdata", prdata2, 0);
    @(negedge pclk);
    preset = 1'b0; sel = 1'b0; penable = 1'b0;
    idle();

    for (int i = 0; i < 80; i++) begin
      w = ($urandom_range(0, 1) == 0) ? 0 : 2;
      r = $urandom_range(0, 9);
      if (r == 0)      a = 32'h400 + 32'($urandom_range(0, 100)) * 4;
      else if (r == 1) a = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
      else             a = 32'($urandom_range(0, 63)) * 4;
      d = $urandom;
      txn(w, $urandom_range(0, 1) == 1, a, d, 4'($urandom), rd);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
